// File: rtl/evm_pkg.sv
// Shared types and helpers for the evm_multi voting machine core.
package evm_pkg;

  // Voter-handling phases of the machine.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_AUTH = 2'd1,
    WAIT_VOTE = 2'd2,
    WAIT_REL  = 2'd3
  } state_t;

  // Widest candidate panel the helpers below accept.
  localparam int MAX_CAND = 16;

  // Bits needed to index n candidates (never less than one).
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // True when exactly one button is pressed.
  function automatic logic is_onehot(input logic [MAX_CAND-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  // Position of the set bit of a one-hot vector (lowest set bit otherwise).
  function automatic logic [3:0] onehot_idx(input logic [MAX_CAND-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = MAX_CAND - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/evm_winner_sel.sv
// Combinational argmax over the flattened vote counters: lowest index holding
// the maximum count, the maximum itself, and whether a non-zero maximum is shared.
module evm_winner_sel
  import evm_pkg::*;
#(
  parameter int N_CAND = 4,
  parameter int CNT_W  = 8
) (
  input  logic [N_CAND*CNT_W-1:0]  counts,
  output logic [idx_w(N_CAND)-1:0] idx,
  output logic [CNT_W-1:0]         max_cnt,
  output logic                     tie
);

  localparam int IDX_W = idx_w(N_CAND);

  logic found_one;
  logic dup;

  // Scan for the strict maximum, then look for a second holder of it.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    idx       = '0;
    max_cnt   = counts[CNT_W-1:0];
    found_one = 1'b0;
    dup       = 1'b0;
    for (int i = 1; i < N_CAND; i++) begin
      if (counts[i*CNT_W +: CNT_W] > max_cnt) begin
        max_cnt = counts[i*CNT_W +: CNT_W];
        idx     = IDX_W'(i);
      end
    end
    for (int i = 0; i < N_CAND; i++) begin
      if (counts[i*CNT_W +: CNT_W] == max_cnt) begin
        if (found_one) dup = 1'b1;
        found_one = 1'b1;
      end
    end
    tie = dup && (max_cnt != '0);
  end

endmodule

// File: rtl/evm_multi.sv
// Electronic voting machine core: per-voter authorisation, one vote per
// authorisation, one-hot button validation, vote timeout, saturating counters
// and registered winner/tie results.
module evm_multi
  import evm_pkg::*;
#(
  parameter int N_CAND      = 4,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            session_en,
  input  logic                            voter_auth,
  input  logic                            clr_counts,
  input  logic [N_CAND-1:0]               button,
  output logic                            ready,
  output logic                            vote_ok,
  output logic                            vote_err,
  output logic                            timeout,
  output logic [N_CAND*CNT_W-1:0]         counts,
  output logic [CNT_W+idx_w(N_CAND)-1:0]  total,
  output logic [idx_w(N_CAND)-1:0]        winner,
  output logic                            tie,
  output logic                            sat
);

  localparam int IDX_W = idx_w(N_CAND);
  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  state_t           state, state_nx;
  logic [TMR_W-1:0] tmr, tmr_nx;
  logic             ok_nx, err_nx, to_nx;
  logic             inc_en, sat_set, clr;

  logic [CNT_W-1:0] cnt [N_CAND];

  logic             btn_valid;
  logic [IDX_W-1:0] btn_idx;
  logic             btn_full;

  logic [IDX_W-1:0] sel_idx;
  logic [CNT_W-1:0] sel_max;
  logic             sel_tie;

  assign btn_valid = is_onehot(MAX_CAND'(button));
  assign btn_idx   = IDX_W'(onehot_idx(MAX_CAND'(button)));
  assign btn_full  = (cnt[btn_idx] == '1);
  assign ready     = (state == WAIT_AUTH);

  for (genvar g = 0; g < N_CAND; g++) begin : g_flat
    assign counts[g*CNT_W +: CNT_W] = cnt[g];
  end

  // State register, vote timer and the registered one-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tmr      <= '0;
      vote_ok  <= 1'b0;
      vote_err <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state    <= state_nx;
      tmr      <= tmr_nx;
      vote_ok  <= ok_nx;
      vote_err <= err_nx;
      timeout  <= to_nx;
    end
  end

  // Next state, timer and pulse/datapath controls; session_en low wins over all.
  always_comb begin
    state_nx = state;
    tmr_nx   = tmr;
    ok_nx    = 1'b0;
    err_nx   = 1'b0;
    to_nx    = 1'b0;
    inc_en   = 1'b0;
    sat_set  = 1'b0;
    clr      = 1'b0;
    case (state)
      IDLE: begin
        clr = clr_counts;
        if (session_en) state_nx = WAIT_AUTH;
      end
      WAIT_AUTH: begin
        if (!session_en) begin
          state_nx = IDLE;
        end else if (voter_auth) begin
          state_nx = WAIT_VOTE;
          tmr_nx   = '0;
        end
      end
      WAIT_VOTE: begin
        if (!session_en) begin
          state_nx = IDLE;
        end else if (btn_valid) begin
          // A single press always consumes the authorisation, counted or not.
          state_nx = WAIT_REL;
          if (btn_full) begin
            err_nx  = 1'b1;
            sat_set = 1'b1;
          end else begin
            ok_nx  = 1'b1;
            inc_en = 1'b1;
          end
        end else if (tmr == TMR_LAST) begin
          to_nx    = 1'b1;
          state_nx = WAIT_AUTH;
        end else begin
          // Idle or multi-press: the clock keeps running; a multi-press is flagged.
          tmr_nx = tmr + 1'b1;
          err_nx = (button != '0);
        end
      end
      WAIT_REL: begin
        if (!session_en)        state_nx = IDLE;
        else if (button == '0)  state_nx = WAIT_AUTH;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Per-candidate counters, running total and the sticky saturation flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the counter array is ordinary flops holding results, so it is reset.
      for (int i = 0; i < N_CAND; i++) cnt[i] <= '0;
      total <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < N_CAND; i++) cnt[i] <= '0;
      total <= '0;
      sat   <= 1'b0;
    end else begin
      if (inc_en) begin
        cnt[btn_idx] <= cnt[btn_idx] + 1'b1;
        total        <= total + 1'b1;
      end
      if (sat_set) sat <= 1'b1;
    end
  end

  evm_winner_sel #(
    .N_CAND (N_CAND),
    .CNT_W  (CNT_W)
  ) u_winner_sel (
    .counts  (counts),
    .idx     (sel_idx),
    .max_cnt (sel_max),
    .tie     (sel_tie)
  );

  // Winner/tie registered one cycle behind the counters; all-zero counts report 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      winner <= '0;
      tie    <= 1'b0;
    end else begin
      winner <= (sel_max == '0) ? '0 : sel_idx;
      tie    <= sel_tie;
    end
  end

endmodule

// File: tb/tb_evm_multi.sv
// Self-checking bench for evm_multi: table of voter transactions plus
// hand-written sequences for held buttons, retries, timeout, session drop,
// counter clearing and asynchronous reset. A scoreboard queue holds the
// expected pulse and counter state for every press driven.
module tb_evm_multi;

  localparam int N      = 4;
  localparam int W      = 2;
  localparam int TO_CYC = 8;

  localparam logic [2:0] P_OK  = 3'b001;
  localparam logic [2:0] P_ERR = 3'b010;
  localparam logic [2:0] P_TO  = 3'b100;

  logic       clk        = 1'b0;
  logic       rst        = 1'b1;
  logic       session_en = 1'b0;
  logic       voter_auth = 1'b0;
  logic       clr_counts = 1'b0;
  logic [3:0] button     = '0;
  logic       ready, vote_ok, vote_err, timeout, tie, sat;
  logic [7:0] counts;
  logic [3:0] total;
  logic [1:0] winner;

  evm_multi #(
    .N_CAND      (N),
    .CNT_W       (W),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .session_en (session_en),
    .voter_auth (voter_auth),
    .clr_counts (clr_counts),
    .button     (button),
    .ready      (ready),
    .vote_ok    (vote_ok),
    .vote_err   (vote_err),
    .timeout    (timeout),
    .counts     (counts),
    .total      (total),
    .winner     (winner),
    .tie        (tie),
    .sat        (sat)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [2:0] pulse;
    logic [7:0] counts;
    logic [3:0] total;
  } sb_t;

  typedef struct {
    logic [3:0] btn;
    logic [1:0] exp_win;
    logic       exp_tie;
    logic       exp_sat;
    logic [3:0] exp_total;
  } vec_t;

  sb_t        sb [$];
  int         m_cnt [4];
  int         m_total = 0;
  logic [1:0] win_at_pulse;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_flat();
    logic [7:0] f;
    for (int i = 0; i < 4; i++) f[i*2 +: 2] = 2'(m_cnt[i]);
    return f;
  endfunction

  // Predict the outcome of a press and queue it for the monitor.
  task automatic push_press(input logic [3:0] b);
    sb_t e;
    int  k;
    k = 0;
    if ($countones(b) == 1) begin
      for (int i = 0; i < 4; i++) if (b[i]) k = i;
      if (m_cnt[k] == 3) begin
        e.pulse = P_ERR;
      end else begin
        m_cnt[k]++;
        m_total++;
        e.pulse = P_OK;
      end
    end else begin
      e.pulse = P_ERR;
    end
    e.counts = model_flat();
    e.total  = 4'(m_total);
    sb.push_back(e);
  endtask

  task automatic push_timeout();
    sb_t e;
    e.pulse  = P_TO;
    e.counts = model_flat();
    e.total  = 4'(m_total);
    sb.push_back(e);
  endtask

  // One voter: called just after a negedge in WAIT_AUTH, returns likewise.
  task automatic do_vote(input logic [3:0] b, input int hold);
    voter_auth = 1'b1;
    @(negedge clk);
    voter_auth = 1'b0;
    button     = b;
    push_press(b);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (k == 0) win_at_pulse = winner;
      check("busy_ready", ready, 0);
    end
    button = '0;
    @(negedge clk);
    check("ready_after_release", ready, 1);
  endtask

  // Scoreboard monitor: every pulse must match the oldest queued prediction.
  always @(negedge clk) begin
    if (!rst && (vote_ok || vote_err || timeout)) begin
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_pulse: got to/err/ok=%b, required none",
                 {timeout, vote_err, vote_ok});
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("pulse_kind", {29'd0, timeout, vote_err, vote_ok}, e.pulse);
        check("pulse_counts", counts, e.counts);
        check("pulse_total", total, e.total);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    vec_t vec [9];
    int   n;
    logic seen;

    vec[0] = '{4'b0100, 2'd2, 1'b0, 1'b0, 4'd1};
    vec[1] = '{4'b0001, 2'd0, 1'b1, 1'b0, 4'd2};
    vec[2] = '{4'b1000, 2'd0, 1'b1, 1'b0, 4'd3};
    vec[3] = '{4'b1000, 2'd3, 1'b0, 1'b0, 4'd4};
    vec[4] = '{4'b1000, 2'd3, 1'b0, 1'b0, 4'd5};
    vec[5] = '{4'b1000, 2'd3, 1'b0, 1'b1, 4'd5};
    vec[6] = '{4'b0010, 2'd3, 1'b0, 1'b1, 4'd6};
    vec[7] = '{4'b0010, 2'd3, 1'b0, 1'b1, 4'd7};
    vec[8] = '{4'b0010, 2'd1, 1'b1, 1'b1, 4'd8};
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_counts", counts, 0);
    check("rst_total", total, 0);
    check("rst_winner", winner, 0);
    check("rst_tie", tie, 0);
    check("rst_sat", sat, 0);
    check("rst_ready", ready, 0);
    check("rst_pulses", {timeout, vote_err, vote_ok}, 0);
    rst        = 1'b0;
    session_en = 1'b1;
    @(negedge clk);
    check("open_ready", ready, 1);

    // Table of single-voter transactions, ending in saturation and a tie.
    for (int i = 0; i < 9; i++) begin
      do_vote(vec[i].btn, 1);
      if (i == 0) check("winner_latency", win_at_pulse, 0);
      check($sformatf("row%0d_winner", i), winner, vec[i].exp_win);
      check($sformatf("row%0d_tie", i), tie, vec[i].exp_tie);
      check($sformatf("row%0d_sat", i), sat, vec[i].exp_sat);
      check($sformatf("row%0d_total", i), total, vec[i].exp_total);
    end

    // Held button counts only once.
    do_vote(4'b0001, 5);
    check("hold_count0", counts[1:0], 2);
    check("hold_winner", winner, 1);

    // Multi-press is rejected, the voter retries with a single press.
    voter_auth = 1'b1;
    @(negedge clk);
    voter_auth = 1'b0;
    button     = 4'b0101;
    push_press(4'b0101);
    @(negedge clk);
    button = 4'b0100;
    push_press(4'b0100);
    @(negedge clk);
    button = '0;
    @(negedge clk);
    check("retry_count2", counts[5:4], 2);
    check("retry_ready", ready, 1);

    // Authorisation expires after TO_CYC cycles in WAIT_VOTE.
    voter_auth = 1'b1;
    @(negedge clk);
    voter_auth = 1'b0;
    push_timeout();
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (timeout) seen = 1'b1;
    end
    check("timeout_cycles", n, TO_CYC);
    check("timeout_ready", ready, 1);
    check("timeout_counts", counts, model_flat());

    // Session drop beats a same-cycle press.
    voter_auth = 1'b1;
    @(negedge clk);
    voter_auth = 1'b0;
    button     = 4'b0001;
    session_en = 1'b0;
    @(negedge clk);
    button = '0;
    check("drop_ready", ready, 0);
    check("drop_counts", counts, model_flat());
    check("drop_pulses", {timeout, vote_err, vote_ok}, 0);

    // Clear ignored in WAIT_AUTH, honoured in IDLE.
    session_en = 1'b1;
    @(negedge clk);
    clr_counts = 1'b1;
    @(negedge clk);
    clr_counts = 1'b0;
    check("clr_ignored_counts", counts, model_flat());
    check("clr_ignored_sat", sat, 1);
    session_en = 1'b0;
    @(negedge clk);
    clr_counts = 1'b1;
    @(negedge clk);
    clr_counts = 1'b0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_total = 0;
    check("clr_counts", counts, 0);
    check("clr_total", total, 0);
    check("clr_sat", sat, 0);
    @(negedge clk);
    check("clr_winner", winner, 0);
    check("clr_tie", tie, 0);

    // Asynchronous reset in WAIT_REL while the vote pulse is still high.
    session_en = 1'b1;
    @(negedge clk);
    voter_auth = 1'b1;
    @(negedge clk);
    voter_auth = 1'b0;
    button     = 4'b0001;
    push_press(4'b0001);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_counts", counts, 0);
    check("arst_total", total, 0);
    check("arst_vote_ok", vote_ok, 0);
    check("arst_ready", ready, 0);
    check("arst_winner", winner, 0);
    check("arst_tie", tie, 0);
    check("arst_sat", sat, 0);
    @(negedge clk);
    button     = '0;
    session_en = 1'b0;
    rst        = 1'b0;
    @(negedge clk);

    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/evm_multi.md
Name: evm_multi

Overview:
- Parametrised electronic voting machine core: N candidates, configurable counter width.
- Adds per-voter authorisation, one-vote-per-authorisation enforcement, one-hot button validation, a vote timeout, saturating counters, and registered winner/tie results.
- Sits between a debounced button panel/officer console and a display/readout block.

Parameters:
- N_CAND, 4, number of candidates (2..16).
- CNT_W, 8, width of each per-candidate vote counter.
- TIMEOUT_CYC, 1000, cycles allowed in WAIT_VOTE before the authorisation expires (>=2).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- session_en  input  1  poll open; low forces IDLE.
- voter_auth  input  1  officer authorises one voter; level sampled each cycle.
- clr_counts  input  1  clear all counters; honoured only in IDLE.
- button  input  N_CAND  candidate buttons, debounced; valid vote is exactly one-hot.
- ready  output  1  high in WAIT_AUTH.
- vote_ok  output  1  one-cycle pulse: vote counted.
- vote_err  output  1  one-cycle pulse: invalid press or saturated counter.
- timeout  output  1  one-cycle pulse: authorisation expired.
- counts  output  N_CAND*CNT_W  flattened counters; candidate i at [i*CNT_W +: CNT_W].
- total  output  CNT_W+$clog2(N_CAND)  sum of counted votes.
- winner  output  $clog2(N_CAND)  index of the highest count.
- tie  output  1  highest count is shared by two or more candidates.
- sat  output  1  sticky: a vote hit a saturated counter.

Behaviour:
- Reset (rst=1, async): state=IDLE; counts, total, winner, tie, sat, ready, vote_ok, vote_err and timeout all 0; timeout counter 0.
- States: IDLE, WAIT_AUTH, WAIT_VOTE, WAIT_REL.
- IDLE: clr_counts=1 zeroes counts, total and sat next cycle. session_en=1 -> WAIT_AUTH.
- WAIT_AUTH: ready=1. voter_auth=1 -> WAIT_VOTE, timer loaded to 0. Buttons ignored.
- WAIT_VOTE:
  - button==0: timer increments. Timer reaching TIMEOUT_CYC-1 -> timeout pulse, go to WAIT_AUTH.
  - button one-hot at index i with counts[i] < max: counts[i]+1, total+1, vote_ok pulse; all registered on the same edge -> WAIT_REL.
  - button one-hot at index i with counts[i] saturated: counts unchanged, vote_err pulse, sat<=1 -> WAIT_REL. The authorisation is consumed.
  - button with more than one bit set: vote_err pulse, stay in WAIT_VOTE, timer keeps running. The voter may retry.
- WAIT_REL: wait for button==0, then -> WAIT_AUTH. Blocks double counting from a held button.
- session_en=0 in any non-IDLE state -> IDLE next edge; a pending authorisation is discarded with no pulse. session_en has priority over a same-cycle vote: no count occurs.
- voter_auth held high: consumed once per entry to WAIT_AUTH. A new vote needs a new WAIT_AUTH visit.
- clr_counts outside IDLE: ignored.
- winner/tie: registered, updated one cycle after any counts change (latency 1 from vote_ok).
  - winner is the lowest index among the candidates holding the max count.
  - tie=1 iff the max count is >0 and held by two or more candidates.
  - All counts zero: winner=0, tie=0.
- total never wraps: its width covers N_CAND*(2^CNT_W-1).
- Pulses last exactly one cycle; at most one of vote_ok, vote_err and timeout is high in any cycle.

Decomposition:
- Package evm_pkg:
  - state enum (IDLE, WAIT_AUTH, WAIT_VOTE, WAIT_REL);
  - IDX_W = $clog2(N_CAND) helper function;
  - onehot check and onehot-to-index functions.
- One sub-module, evm_winner_sel: combinational argmax over the flattened counts, producing index, max and tie. Instantiated once; its outputs are registered in evm_multi.

Test Plan:
- Reset, open session, auth, press button=4'b0100, release -> vote_ok one cycle, counts[2]=1, total=1; winner=2, tie=0 one cycle later.
- Auth, hold button=4'b0001 for 5 cycles -> exactly one vote_ok, counts[0]=1, FSM in WAIT_REL until release, then ready=1.
- Auth, press 4'b0110, then 4'b0010 -> vote_err pulse, then vote_ok, counts[1]+1; first press uncounted.
- TIMEOUT_CYC=8: auth with no press -> timeout pulse after 8 cycles in WAIT_VOTE, ready=1, counts unchanged.
- CNT_W=2: four votes for candidate 3 -> counts[3]=3, 4th gives vote_err and sat=1; one vote each for candidates 0 and 3... then equal max of 3 on candidates 1 and 3 -> winner=1, tie=1.
- session_en drop while in WAIT_VOTE with same-cycle press -> IDLE, no pulse, counts unchanged. clr_counts in WAIT_AUTH is ignored; clr_counts in IDLE gives all counts=0, sat=0. Assert rst mid-WAIT_REL -> all outputs 0 immediately.
